tdm_demux: RTL and testbench

- Receive end of the team's time-division multiplexed word stream: one input word per valid cycle, channel 0 marked by a start-of-frame flag.
- Routes each word to its channel's holding register and tracks frame position with a counter and a two-state sync FSM.
- Flags complete frames and framing errors. Sits downstream of the mux-based TDM combiner.

---
 rtl/tdm_pkg.sv | 22 ++
 rtl/tdm_chan_reg.sv | 41 ++++
 rtl/tdm_demux.sv | 143 ++++++++++++++
 tb/tb_tdm_demux.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// tdm_pkg
// Shared definitions for the TDM receive demultiplexer.
//   ST_SYNC / ST_RUN : encodings of the two-state frame sync FSM
//   MAX_NCH          : largest supported channel count
//   chanOneHot()     : one-hot channel mask for a channel index
package tdm_pkg;

   localparam logic ST_SYNC = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   localparam int MAX_NCH = 16;

   // Bit idx is set in the returned mask.
   // Callers narrow the result to their own channel count.
   function automatic logic [MAX_NCH-1:0] chanOneHot(input logic [3:0] idx);
      logic [MAX_NCH-1:0] mask;
      mask      = '0;
      mask[idx] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/tdm_chan_reg.sv
// tdm_chan_reg
// Holding register for one TDM channel. A load captures data_i and raises
// valid_o for exactly one cycle. The held data persists until the next load.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   load_i  : capture data_i on this edge
//   data_i  : word to capture
//   data_o  : held channel word
//   valid_o : one-cycle pulse following a load
module tdm_chan_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o
);

   logic [WIDTH-1:0] dataQ;
   logic             validQ;

   // The data word is held across idle cycles.
   // The valid flag simply mirrors the load, so it drops again on the next edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dataQ  <= '0;
         validQ <= 1'b0;
      end else begin
         if (load_i) begin
            dataQ <= data_i;
         end
         validQ <= load_i;
      end
   end

   assign data_o  = dataQ;
   assign valid_o = validQ;

endmodule

// File: rtl/tdm_demux.sv
// tdm_demux
// Receive side of the TDM word stream. Each accepted word goes to the holding
// register of its channel. A counter plus a SYNC/RUN FSM track the position
// within the frame, and the block flags complete frames and framing errors.
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   in_data    : incoming TDM word
//   in_valid   : in_data is valid this cycle
//   in_sof     : start of frame (channel-0 word); ignored when in_valid=0
//   out_data   : channel k held in bits [k*WIDTH +: WIDTH]
//   out_valid  : one-cycle pulse on bit k when channel k is updated
//   chan_idx   : channel the next accepted word will be written to
//   frame_done : one-cycle pulse when the last channel is written
//   frame_err  : one-cycle pulse on a framing error
//   synced     : FSM is in RUN
module tdm_demux
   import tdm_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NCH   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         in_data,
   input  logic                     in_valid,
   input  logic                     in_sof,
   output logic [NCH*WIDTH-1:0]     out_data,
   output logic [NCH-1:0]           out_valid,
   output logic [$clog2(NCH)-1:0]   chan_idx,
   output logic                     frame_done,
   output logic                     frame_err,
   output logic                     synced
);

   localparam int CW = $clog2(NCH);
   localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

   logic          stateQ, stateD;
   logic [CW-1:0] idxQ, idxD;
   logic          wrEn;
   logic [CW-1:0] wrChan;
   logic          doneD, errD;
   logic          doneQ, errQ;
   logic [NCH-1:0] loadMask;

   // State register: the FSM state and the frame position counter.
   // Both change only on accepted words.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateQ <= ST_SYNC;
         idxQ   <= '0;
      end else begin
         stateQ <= stateD;
         idxQ   <= idxD;
      end
   end

   // Next-state logic. Any sof word restarts the frame at channel 1.
   // In RUN, a non-sof word arriving when channel 0 is expected means sync
   // was lost. The counter wraps explicitly at the last channel, so it stays
   // below NCH even when NCH is not a power of two.
   always_comb begin
      stateD = stateQ;
      idxD   = idxQ;
      if (in_valid) begin
         if (stateQ == ST_SYNC) begin
            if (in_sof) begin
               stateD = ST_RUN;
               idxD   = CW'(1);
            end
         end else begin
            if (in_sof) begin
               idxD = CW'(1);
            end else if (idxQ == '0) begin
               stateD = ST_SYNC;
            end else if (idxQ == LAST_CH) begin
               idxD = '0;
            end else begin
               idxD = idxQ + CW'(1);
            end
         end
      end
   end

   // Output decode: which channel (if any) is written, and the frame status pulses.
   // A short frame is an sof word that arrives before the counter has wrapped.
   // It is reported as an error, and the word still starts a new frame.
   always_comb begin
      wrEn   = 1'b0;
      wrChan = '0;
      doneD  = 1'b0;
      errD   = 1'b0;
      if (in_valid) begin
         if (stateQ == ST_SYNC) begin
            if (in_sof) begin
               wrEn = 1'b1;
            end
         end else begin
            if (in_sof) begin
               wrEn = 1'b1;
               errD = (idxQ != '0);
            end else if (idxQ == '0) begin
               errD = 1'b1;
            end else begin
               wrEn   = 1'b1;
               wrChan = idxQ;
               doneD  = (idxQ == LAST_CH);
            end
         end
      end
   end

   // The status pulses are registered so that they line up with the
   // out_valid pulse of the word that caused them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         doneQ <= 1'b0;
         errQ  <= 1'b0;
      end else begin
         doneQ <= doneD;
         errQ  <= errD;
      end
   end

   assign loadMask = wrEn ? NCH'(chanOneHot(4'(wrChan))) : '0;

   for (genvar k = 0; k < NCH; k++) begin : gChan
      tdm_chan_reg #(.WIDTH(WIDTH)) uChanReg (
         .clk     (clk),
         .rst     (rst),
         .load_i  (loadMask[k]),
         .data_i  (in_data),
         .data_o  (out_data[k*WIDTH +: WIDTH]),
         .valid_o (out_valid[k])
      );
   end

   assign chan_idx   = idxQ;
   assign frame_done = doneQ;
   assign frame_err  = errQ;
   assign synced     = (stateQ == ST_RUN);

endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux
// Directed, table-driven bench. It drives one NCH=4 instance and one NCH=3 instance.
module tb_tdm_demux;

   logic        clk;
   logic        rst;

   logic [7:0]  inData4;
   logic        inValid4, inSof4;
   logic [31:0] outData4;
   logic [3:0]  outValid4;
   logic [1:0]  chanIdx4;
   logic        frameDone4, frameErr4, synced4;

   logic [7:0]  inData3;
   logic        inValid3, inSof3;
   logic [23:0] outData3;
   logic [2:0]  outValid3;
   logic [1:0]  chanIdx3;
   logic        frameDone3, frameErr3, synced3;

   int checkCount = 0;
   int passCount  = 0;

   typedef struct {
      logic        valid;
      logic        sof;
      logic [7:0]  data;
      logic [3:0]  expValid;
      logic [1:0]  expIdx;
      logic        expDone;
      logic        expErr;
      logic        expSynced;
      logic [31:0] expData;
   } vec_t;

   vec_t vecs[19];

   tdm_demux #(.WIDTH(8), .NCH(4)) dut4 (
      .clk        (clk),
      .rst        (rst),
      .in_data    (inData4),
      .in_valid   (inValid4),
      .in_sof     (inSof4),
      .out_data   (outData4),
      .out_valid  (outValid4),
      .chan_idx   (chanIdx4),
      .frame_done (frameDone4),
      .frame_err  (frameErr4),
      .synced     (synced4)
   );

   tdm_demux #(.WIDTH(8), .NCH(3)) dut3 (
      .clk        (clk),
      .rst        (rst),
      .in_data    (inData3),
      .in_valid   (inValid3),
      .in_sof     (inSof3),
      .out_data   (outData3),
      .out_valid  (outValid3),
      .chan_idx   (chanIdx3),
      .frame_done (frameDone3),
      .frame_err  (frameErr3),
      .synced     (synced3)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic v, input logic s, input logic [7:0] d,
                               input logic [3:0] ev, input logic [1:0] ei,
                               input logic ed, input logic ee, input logic es,
                               input logic [31:0] eData);
      vec_t r;
      r.valid = v; r.sof = s; r.data = d;
      r.expValid = ev; r.expIdx = ei; r.expDone = ed; r.expErr = ee;
      r.expSynced = es; r.expData = eData;
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checkCount++;
      if (act === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Drive one word on the falling edge, then let the rising edge take it.
   // Outputs are sampled 1 unit after that edge.
   task automatic applyStimulus(input bit toThree, input logic v, input logic s, input logic [7:0] d);
      @(negedge clk);
      if (toThree) begin
         inValid3 = v; inSof3 = s; inData3 = d;
      end else begin
         inValid4 = v; inSof4 = s; inData4 = d;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic runVectors(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         applyStimulus(1'b0, vecs[i].valid, vecs[i].sof, vecs[i].data);
         checkOutput($sformatf("v%0d.outValid", i), 64'(outValid4), 64'(vecs[i].expValid));
         checkOutput($sformatf("v%0d.chanIdx", i), 64'(chanIdx4), 64'(vecs[i].expIdx));
         checkOutput($sformatf("v%0d.frameDone", i), 64'(frameDone4), 64'(vecs[i].expDone));
         checkOutput($sformatf("v%0d.frameErr", i), 64'(frameErr4), 64'(vecs[i].expErr));
         checkOutput($sformatf("v%0d.synced", i), 64'(synced4), 64'(vecs[i].expSynced));
         checkOutput($sformatf("v%0d.outData", i), 64'(outData4), 64'(vecs[i].expData));
      end
   endtask

   initial begin
      logic [23:0] expData3;
      logic [7:0]  word;
      int          doneSeen;
      int          errSeen;
      logic [1:0]  idxBefore;

      // Full frame, a missing sof with recovery, and a short frame with resync.
      vecs[0]  = mk(1, 1, 8'hA0, 4'b0001, 2'd1, 0, 0, 1, 32'h000000A0);
      vecs[1]  = mk(1, 0, 8'hB1, 4'b0010, 2'd2, 0, 0, 1, 32'h0000B1A0);
      vecs[2]  = mk(1, 0, 8'hC2, 4'b0100, 2'd3, 0, 0, 1, 32'h00C2B1A0);
      vecs[3]  = mk(1, 0, 8'hD3, 4'b1000, 2'd0, 1, 0, 1, 32'hD3C2B1A0);
      vecs[4]  = mk(1, 0, 8'h55, 4'b0000, 2'd0, 0, 1, 0, 32'hD3C2B1A0);
      vecs[5]  = mk(0, 0, 8'h77, 4'b0000, 2'd0, 0, 0, 0, 32'hD3C2B1A0);
      vecs[6]  = mk(1, 0, 8'h66, 4'b0000, 2'd0, 0, 0, 0, 32'hD3C2B1A0);
      vecs[7]  = mk(1, 1, 8'h01, 4'b0001, 2'd1, 0, 0, 1, 32'hD3C2B101);
      vecs[8]  = mk(1, 0, 8'h02, 4'b0010, 2'd2, 0, 0, 1, 32'hD3C20201);
      vecs[9]  = mk(0, 1, 8'hEE, 4'b0000, 2'd2, 0, 0, 1, 32'hD3C20201);
      vecs[10] = mk(1, 1, 8'h10, 4'b0001, 2'd1, 0, 1, 1, 32'hD3C20210);
      vecs[11] = mk(1, 0, 8'h20, 4'b0010, 2'd2, 0, 0, 1, 32'hD3C22010);
      vecs[12] = mk(1, 0, 8'h30, 4'b0100, 2'd3, 0, 0, 1, 32'hD3302010);
      vecs[13] = mk(1, 0, 8'h40, 4'b1000, 2'd0, 1, 0, 1, 32'h40302010);
      vecs[14] = mk(1, 1, 8'h50, 4'b0001, 2'd1, 0, 0, 1, 32'h40302050);
      vecs[15] = mk(1, 0, 8'h60, 4'b0010, 2'd2, 0, 0, 1, 32'h40306050);
      // After the mid-frame reset: non-sof words are dropped until an sof word arrives.
      vecs[16] = mk(1, 0, 8'h11, 4'b0000, 2'd0, 0, 0, 0, 32'h00000000);
      vecs[17] = mk(1, 0, 8'h22, 4'b0000, 2'd0, 0, 0, 0, 32'h00000000);
      vecs[18] = mk(1, 1, 8'h33, 4'b0001, 2'd1, 0, 0, 1, 32'h00000033);

      inData4 = '0; inValid4 = 1'b0; inSof4 = 1'b0;
      inData3 = '0; inValid3 = 1'b0; inSof3 = 1'b0;
      rst = 1'b1;
      #3;
      checkOutput("rst.outData4", 64'(outData4), 64'd0);
      checkOutput("rst.outValid4", 64'(outValid4), 64'd0);
      checkOutput("rst.chanIdx4", 64'(chanIdx4), 64'd0);
      checkOutput("rst.done4", 64'(frameDone4), 64'd0);
      checkOutput("rst.err4", 64'(frameErr4), 64'd0);
      checkOutput("rst.synced4", 64'(synced4), 64'd0);
      checkOutput("rst.outData3", 64'(outData3), 64'd0);
      checkOutput("rst.synced3", 64'(synced3), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      runVectors(0, 15);

      // Asynchronous reset between edges while chan_idx is 2.
      @(negedge clk);
      inValid4 = 1'b0;
      #1 rst = 1'b1;
      #1;
      checkOutput("arst.outData", 64'(outData4), 64'd0);
      checkOutput("arst.outValid", 64'(outValid4), 64'd0);
      checkOutput("arst.chanIdx", 64'(chanIdx4), 64'd0);
      checkOutput("arst.synced", 64'(synced4), 64'd0);
      checkOutput("arst.done", 64'(frameDone4), 64'd0);
      checkOutput("arst.err", 64'(frameErr4), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      runVectors(16, 18);

      // NCH=3: three back-to-back frames with idle gaps in between.
      expData3 = '0;
      doneSeen = 0;
      errSeen  = 0;
      for (int f = 0; f < 3; f++) begin
         for (int c = 0; c < 3; c++) begin
            if (((f + c) % 2) == 1) begin
               idxBefore = chanIdx3;
               applyStimulus(1'b1, 1'b0, 1'b0, 8'hFF);
               checkOutput($sformatf("n3.f%0dc%0d.gapIdx", f, c), 64'(chanIdx3), 64'(idxBefore));
               checkOutput($sformatf("n3.f%0dc%0d.gapValid", f, c), 64'(outValid3), 64'd0);
               checkOutput($sformatf("n3.f%0dc%0d.gapData", f, c), 64'(outData3), 64'(expData3));
               if (frameDone3) doneSeen++;
               if (frameErr3) errSeen++;
            end
            word = 8'((f + 1) * 16 + c);
            expData3[c*8 +: 8] = word;
            applyStimulus(1'b1, 1'b1, (c == 0), word);
            checkOutput($sformatf("n3.f%0dc%0d.idx", f, c), 64'(chanIdx3), 64'((c + 1) % 3));
            checkOutput($sformatf("n3.f%0dc%0d.valid", f, c), 64'(outValid3), 64'(3'b001 << c));
            checkOutput($sformatf("n3.f%0dc%0d.data", f, c), 64'(outData3), 64'(expData3));
            checkOutput($sformatf("n3.f%0dc%0d.done", f, c), 64'(frameDone3), 64'(c == 2));
            if (frameDone3) doneSeen++;
            if (frameErr3) errSeen++;
         end
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      checkOutput("n3.donePulses", 64'(doneSeen), 64'd3);
      checkOutput("n3.errPulses", 64'(errSeen), 64'd0);
      checkOutput("n3.synced", 64'(synced3), 64'd1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
